// File: rtl/delay_sample_accum_pkg.sv
// ============================================================================
// Module : delay_sample_accum_pkg
// Brief  : Shared FSM state encoding and default sizing for delay_sample_accum
// Rev    : 1.0
// ============================================================================
`default_nettype none

package delay_sample_accum_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT    = 2'd1,
        S_CAPTURED = 2'd2,
        S_REPORT   = 2'd3
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_NS_LOG2 = 3;

endpackage

`default_nettype wire

// File: rtl/min_max_sum.sv
// ============================================================================
// Module : min_max_sum
// Brief  : Running min/max/sum of committed samples; first sample seeds min/max
// Rev    : 1.0
// ============================================================================
`default_nettype none

module min_max_sum
    import delay_sample_accum_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int NS_LOG2 = DEF_NS_LOG2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     commit,
    input  logic                     clear,
    input  logic                     first,
    input  logic [CNT_W-1:0]         sample,
    output logic [CNT_W-1:0]         next_min,
    output logic [CNT_W-1:0]         next_max,
    output logic [CNT_W+NS_LOG2-1:0] next_sum
);

    localparam int SUM_W = CNT_W + NS_LOG2;

    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [SUM_W-1:0] r_sum;

    // Values the stats take if the current sample is committed this cycle.
    always_comb begin
        next_min = r_min;
        next_max = r_max;
        next_sum = r_sum;
        if (first) begin
            next_min = sample;
            next_max = sample;
            next_sum = SUM_W'(sample);
        end else begin
            if (sample < r_min) next_min = sample;
            if (sample > r_max) next_max = sample;
            next_sum = r_sum + SUM_W'(sample);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
        end else if (clear) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
        end else if (commit) begin
            r_min <= next_min;
            r_max <= next_max;
            r_sum <= next_sum;
        end
    end

endmodule

`default_nettype wire

// File: rtl/delay_sample_accum.sv
// ============================================================================
// Module : delay_sample_accum
// Brief  : Measures path delay samples and reports min/max/avg every 2^NS_LOG2
// Rev    : 1.0
// ============================================================================
`default_nettype none

module delay_sample_accum
    import delay_sample_accum_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int NS_LOG2 = DEF_NS_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pathInput,
    input  logic             ld_reg,
    input  logic             fin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_min,
    output logic [CNT_W-1:0] res_max,
    output logic [CNT_W-1:0] res_avg,
    output logic [1:0]       res_flags
);

    localparam int                 SUM_W     = CNT_W + NS_LOG2;
    localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;
    localparam logic [NS_LOG2:0]   C_NS      = (NS_LOG2 + 1)'(2 ** NS_LOG2);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_sample;
    logic [NS_LOG2:0]   r_count;
    logic [1:0]         r_flags;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NS_LOG2:0]   w_count_inc;
    logic               w_commit;
    logic               w_clear;
    logic               w_first;
    logic [CNT_W-1:0]   w_next_min;
    logic [CNT_W-1:0]   w_next_max;
    logic [SUM_W-1:0]   w_next_sum;
    logic [CNT_W-1:0]   w_next_avg;

    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_count_inc = r_count + 1'b1;
    assign w_commit    = (r_state == S_CAPTURED) && fin;
    assign w_clear     = (r_state == S_REPORT) && res_ready;
    assign w_first     = (r_count == '0);
    assign w_next_avg  = CNT_W'(w_next_sum >> NS_LOG2);

    min_max_sum #(
        .CNT_W   (CNT_W),
        .NS_LOG2 (NS_LOG2)
    ) u_min_max_sum (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit   (w_commit),
        .clear    (w_clear),
        .first    (w_first),
        .sample   (r_sample),
        .next_min (w_next_min),
        .next_max (w_next_max),
        .next_sum (w_next_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sample  <= '0;
            r_count   <= '0;
            r_flags   <= '0;
            res_valid <= 1'b0;
            res_min   <= '0;
            res_max   <= '0;
            res_avg   <= '0;
            res_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (pathInput) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // A capture strobe wins over a simultaneous increment.
                    if (ld_reg) begin
                        r_sample <= r_cnt;
                        r_state  <= S_CAPTURED;
                    end else if (pathInput && (r_cnt != C_CNT_MAX)) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_CNT_MAX) r_flags[0] <= 1'b1;
                    end
                end
                S_CAPTURED: begin
                    if (fin) begin
                        r_cnt   <= '0;
                        r_count <= w_count_inc;
                        if (w_count_inc == C_NS) begin
                            r_state   <= S_REPORT;
                            res_valid <= 1'b1;
                            res_min   <= w_next_min;
                            res_max   <= w_next_max;
                            res_avg   <= w_next_avg;
                            res_flags <= r_flags;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (pathInput) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_COUNT;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_state   <= S_IDLE;
                        r_count   <= '0;
                        r_flags   <= '0;
                        res_valid <= 1'b0;
                        res_min   <= '0;
                        res_max   <= '0;
                        res_avg   <= '0;
                        res_flags <= '0;
                    end else if (ld_reg) begin
                        r_flags[1]   <= 1'b1;
                        res_flags[1] <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delay_sample_accum.sv
// ============================================================================
// Module : tb_delay_sample_accum
// Brief  : Directed table-driven bench for delay_sample_accum
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_delay_sample_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        path_a, ld_a, fin_a, rdy_a;
    logic        valid_a;
    logic [15:0] min_a, max_a, avg_a;
    logic [1:0]  flags_a;
    logic        path_b, ld_b, fin_b, rdy_b;
    logic        valid_b;
    logic [3:0]  min_b, max_b, avg_b;
    logic [1:0]  flags_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    delay_sample_accum #(.CNT_W(16), .NS_LOG2(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .pathInput(path_a), .ld_reg(ld_a), .fin(fin_a),
        .res_valid(valid_a), .res_ready(rdy_a), .res_min(min_a), .res_max(max_a),
        .res_avg(avg_a), .res_flags(flags_a)
    );

    delay_sample_accum #(.CNT_W(4), .NS_LOG2(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pathInput(path_b), .ld_reg(ld_b), .fin(fin_b),
        .res_valid(valid_b), .res_ready(rdy_b), .res_min(min_b), .res_max(max_b),
        .res_avg(avg_b), .res_flags(flags_b)
    );

    typedef struct {
        logic [7:0][7:0] lens;
        logic [15:0]     emin;
        logic [15:0]     emax;
        logic [15:0]     eavg;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [7:0][7:0] pack8(input int a, b, c, d, e, f, g, h);
        logic [7:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        r[4] = 8'(e); r[5] = 8'(f); r[6] = 8'(g); r[7] = 8'(h);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full sample on dut_a: launch n cycles, capture, then commit.
    task automatic sample_a(input int n);
        path_a = 1'b1;
        repeat (n) tick();
        path_a = 1'b0;
        ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        fin_a = 1'b1;
        tick();
        fin_a = 1'b0;
    endtask

    task automatic report_a(input logic [7:0][7:0] lens, input logic [15:0] emin,
                            input logic [15:0] emax, input logic [15:0] eavg, input string tag);
        for (int i = 0; i < 7; i++) sample_a(int'(lens[i]));
        check({tag, " valid before 8th"}, valid_a, 0);
        sample_a(int'(lens[7]));
        check({tag, " valid"}, valid_a, 1);
        check({tag, " min"}, min_a, emin);
        check({tag, " max"}, max_a, emax);
        check({tag, " avg"}, avg_a, eavg);
        check({tag, " flags"}, flags_a, 0);
    endtask

    task automatic ack_a(input string tag);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        check({tag, " ack valid"}, valid_a, 0);
        check({tag, " ack min"}, min_a, 0);
        check({tag, " ack max"}, max_a, 0);
        check({tag, " ack avg"}, avg_a, 0);
        check({tag, " ack flags"}, flags_a, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset valid_a", valid_a, 0);
        check("reset min_a", min_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {path_a, ld_a, fin_a, rdy_a} = '0;
        {path_b, ld_b, fin_b, rdy_b} = '0;
        vecs[0] = '{pack8(5, 7, 3, 9, 4, 6, 8, 2),         16'd2,  16'd9,  16'd5};
        vecs[1] = '{pack8(1, 2, 3, 4, 5, 6, 7, 8),         16'd1,  16'd8,  16'd4};
        vecs[2] = '{pack8(10, 10, 10, 10, 10, 10, 10, 11), 16'd10, 16'd11, 16'd10};
        vecs[3] = '{pack8(12, 1, 12, 12, 12, 12, 12, 12),  16'd1,  16'd12, 16'd10};

        tick();
        check("reset valid", valid_a, 0);
        check("reset min", min_a, 0);
        check("reset max", max_a, 0);
        check("reset avg", avg_a, 0);
        check("reset flags", flags_a, 0);
        check("reset valid_b", valid_b, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            report_a(vecs[i].lens, vecs[i].emin, vecs[i].emax, vecs[i].eavg, $sformatf("vec%0d", i));
            ack_a($sformatf("vec%0d", i));
        end

        // Held report with a dropped sample, then stats must restart clean.
        report_a(vecs[0].lens, 16'd2, 16'd9, 16'd5, "hold");
        for (int c = 0; c < 10; c++) begin
            ld_a = (c == 3);
            tick();
            ld_a = 1'b0;
            if (c == 2) check("hold flags pre-drop", flags_a, 0);
        end
        check("hold valid", valid_a, 1);
        check("hold min", min_a, 2);
        check("hold max", max_a, 9);
        check("hold avg", avg_a, 5);
        check("hold flags", flags_a, 2);
        ack_a("hold");
        report_a(pack8(4, 4, 4, 4, 4, 4, 4, 4), 16'd4, 16'd4, 16'd4, "post-hold");
        ack_a("post-hold");

        // ld_reg together with pathInput at count 4 captures 4.
        for (int i = 0; i < 8; i++) begin
            path_a = 1'b1;
            repeat (4) tick();
            ld_a = 1'b1;
            tick();
            path_a = 1'b0;
            ld_a = 1'b0;
            fin_a = 1'b1;
            tick();
            fin_a = 1'b0;
            if (i == 6) check("prio valid before 8th", valid_a, 0);
        end
        check("prio valid", valid_a, 1);
        check("prio min", min_a, 4);
        check("prio max", max_a, 4);
        check("prio avg", avg_a, 4);
        ack_a("prio");

        // Relaunch from CAPTURED discards the sample; new count starts at 1.
        path_a = 1'b1;
        repeat (9) tick();
        path_a = 1'b0;
        ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        path_a = 1'b1;
        repeat (2) tick();
        path_a = 1'b0;
        ld_a = 1'b1;
        tick();
        ld_a = 1'b0;
        fin_a = 1'b1;
        tick();
        fin_a = 1'b0;
        for (int i = 0; i < 6; i++) sample_a(6);
        check("relaunch valid before 8th", valid_a, 0);
        sample_a(6);
        check("relaunch valid", valid_a, 1);
        check("relaunch min", min_a, 2);
        check("relaunch max", max_a, 6);
        check("relaunch avg", avg_a, 5);
        ack_a("relaunch");

        // Reset mid-COUNT after 5 commits discards all partial data.
        for (int i = 0; i < 5; i++) sample_a(7);
        path_a = 1'b1;
        repeat (3) tick();
        path_a = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        check("post-reset no report", valid_a, 0);
        report_a(pack8(3, 3, 3, 3, 3, 3, 3, 3), 16'd3, 16'd3, 16'd3, "post-reset");
        ack_a("post-reset");

        // Saturation on the 4-bit, one-sample-per-report instance.
        path_b = 1'b1;
        repeat (20) tick();
        path_b = 1'b0;
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        fin_b = 1'b1;
        tick();
        fin_b = 1'b0;
        check("sat valid", valid_b, 1);
        check("sat min", min_b, 15);
        check("sat max", max_b, 15);
        check("sat avg", avg_b, 15);
        check("sat flags", flags_b, 1);
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        check("sat ack valid", valid_b, 0);
        check("sat ack flags", flags_b, 0);
        path_b = 1'b1;
        repeat (6) tick();
        path_b = 1'b0;
        ld_b = 1'b1;
        tick();
        ld_b = 1'b0;
        fin_b = 1'b1;
        tick();
        fin_b = 1'b0;
        check("nosat valid", valid_b, 1);
        check("nosat avg", avg_b, 6);
        check("nosat flags", flags_b, 0);
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
